// File: rtl/voice_sequencer_pkg.sv
// Shared types and constants for the voice sequencer and its generator bus.
package voice_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEL,
    WAIT,
    DONE
  } seq_state_e;

  localparam int unsigned VOICE_IDX_W = 2;
  localparam int unsigned FREQ_W      = 16;
  localparam int unsigned PW_W        = 12;
  localparam int unsigned WSEL_W      = 4;

  localparam logic [WSEL_W-1:0] WSEL_TRI   = 4'b0001;
  localparam logic [WSEL_W-1:0] WSEL_SAW   = 4'b0010;
  localparam logic [WSEL_W-1:0] WSEL_PULSE = 4'b0100;
  localparam logic [WSEL_W-1:0] WSEL_NOISE = 4'b1000;

endpackage

// File: rtl/voice_sequencer_if.sv
// Start/ready handshake bus between the sequencer (master) and the voice generator (slave).
interface voice_sequencer_if #(
  parameter int unsigned WAVE_W = 10
) ();
  import voice_pkg::*;

  logic                   start;
  logic [VOICE_IDX_W-1:0] voice;
  logic [FREQ_W-1:0]      freq;
  logic [PW_W-1:0]        pw;
  logic [WSEL_W-1:0]      wave_sel;
  logic                   ready;
  logic [WAVE_W-1:0]      wave;

  modport master (
    output start, voice, freq, pw, wave_sel,
    input  ready, wave
  );

  modport slave (
    input  start, voice, freq, pw, wave_sel,
    output ready, wave
  );

endinterface

// File: rtl/voice_sequencer.sv
// Per-sample scheduler: snapshots voice config on a tick, runs each enabled voice
// through the shared generator, and publishes the captured samples as one frame.
module voice_sequencer
  import voice_pkg::*;
#(
  parameter int unsigned NUM_VOICES     = 3,
  parameter int unsigned WAVE_W         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         sample_tick_i,
  input  logic [NUM_VOICES-1:0]        voice_en_i,
  input  logic [16*NUM_VOICES-1:0]     freq_words_i,
  input  logic [12*NUM_VOICES-1:0]     pw_words_i,
  input  logic [4*NUM_VOICES-1:0]      wave_sels_i,
  input  logic                         clr_status_i,
  voice_sequencer_if.master            gen,
  output logic [WAVE_W*NUM_VOICES-1:0] samples_o,
  output logic                         frame_valid_o,
  output logic                         busy_o,
  output logic                         overrun_o,
  output logic                         timeout_o
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [VOICE_IDX_W-1:0] LAST_IDX = VOICE_IDX_W'(NUM_VOICES - 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  seq_state_e state_q, state_d;
  logic [VOICE_IDX_W-1:0] idx_q, idx_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic [NUM_VOICES-1:0]        snap_en_q;
  logic [16*NUM_VOICES-1:0]     snap_freq_q;
  logic [12*NUM_VOICES-1:0]     snap_pw_q;
  logic [4*NUM_VOICES-1:0]      snap_wsel_q;
  logic [WAVE_W*NUM_VOICES-1:0] work_q, work_d;
  logic [WAVE_W*NUM_VOICES-1:0] samples_q;
  logic valid_q, overrun_q, timeout_q;

  logic start, publish, timeout_evt, last;
  logic take_tick, overrun_evt;

  assign last        = (idx_q == LAST_IDX);
  assign take_tick   = sample_tick_i && (state_q == IDLE);
  assign overrun_evt = sample_tick_i && (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wd_d        = wd_q;
    work_d      = work_q;
    start       = 1'b0;
    publish     = 1'b0;
    timeout_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_tick_i) begin
          state_d = SEL;
          idx_d   = '0;
        end
      end
      SEL: begin
        if (snap_en_q[idx_q]) begin
          start   = 1'b1;
          wd_d    = '0;
          state_d = WAIT;
        end else begin
          work_d[idx_q*WAVE_W +: WAVE_W] = '0;
          if (last) state_d = DONE;
          else      idx_d   = idx_q + 1'b1;
        end
      end
      WAIT: begin
        // Ready wins over a watchdog expiry landing in the same cycle.
        if (gen.ready || (wd_q == WD_LIMIT)) begin
          work_d[idx_q*WAVE_W +: WAVE_W] = gen.ready ? gen.wave : '0;
          timeout_evt = !gen.ready;
          if (last) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SEL;
          end
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      DONE: begin
        publish = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wd_q        <= '0;
      snap_en_q   <= '0;
      snap_freq_q <= '0;
      snap_pw_q   <= '0;
      snap_wsel_q <= '0;
      work_q      <= '0;
      samples_q   <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      work_q  <= work_d;
      valid_q <= publish;
      if (take_tick) begin
        snap_en_q   <= voice_en_i;
        snap_freq_q <= freq_words_i;
        snap_pw_q   <= pw_words_i;
        snap_wsel_q <= wave_sels_i;
      end
      if (publish) samples_q <= work_q;
      // Set events take priority over a simultaneous clear.
      if (overrun_evt)       overrun_q <= 1'b1;
      else if (clr_status_i) overrun_q <= 1'b0;
      if (timeout_evt)       timeout_q <= 1'b1;
      else if (clr_status_i) timeout_q <= 1'b0;
    end
  end

  assign gen.start    = start;
  assign gen.voice    = idx_q;
  assign gen.freq     = snap_freq_q[idx_q*FREQ_W +: FREQ_W];
  assign gen.pw       = snap_pw_q[idx_q*PW_W +: PW_W];
  assign gen.wave_sel = snap_wsel_q[idx_q*WSEL_W +: WSEL_W];

  assign samples_o     = samples_q;
  assign frame_valid_o = valid_q;
  assign busy_o        = (state_q != IDLE);
  assign overrun_o     = overrun_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_voice_sequencer.sv
// Directed bench for voice_sequencer with a fixed-latency generator model.
module tb_voice_sequencer;
  import voice_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        tick = 1'b0;
  logic [2:0]  voice_en = '0;
  logic [47:0] freq_words = '0;
  logic [35:0] pw_words = {12'h300, 12'h200, 12'h100};
  logic [11:0] wave_sels = {WSEL_PULSE, WSEL_SAW, WSEL_TRI};
  logic        clr = 1'b0;
  logic [29:0] samples;
  logic        frame_valid, busy, overrun, timeout;

  logic [1:0]  mute_voice = 2'd3;
  logic [2:0]  sr;
  logic [47:0] cur_freq;
  logic [47:0] frame_freq;

  int checks = 0;
  int failures = 0;

  int unsigned r_mask, r_nstarts, r_nvalid, r_valid_cyc, r_busy1;
  logic [7:0]  r_voices;
  logic [15:0] r_freq2;

  voice_sequencer_if #(.WAVE_W(10)) gen_bus ();

  voice_sequencer #(
    .NUM_VOICES(3),
    .WAVE_W(10),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .sample_tick_i(tick),
    .voice_en_i(voice_en),
    .freq_words_i(freq_words),
    .pw_words_i(pw_words),
    .wave_sels_i(wave_sels),
    .clr_status_i(clr),
    .gen(gen_bus),
    .samples_o(samples),
    .frame_valid_o(frame_valid),
    .busy_o(busy),
    .overrun_o(overrun),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  // Generator: ready three cycles after start, sample = 0x100 + voice; one voice may be muted.
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) sr <= '0;
    else         sr <= {sr[1:0], gen_bus.start && (gen_bus.voice != mute_voice)};
  end
  assign gen_bus.ready = sr[2];
  assign gen_bus.wave  = 10'h100 + 10'(gen_bus.voice);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  task automatic run_frame(input logic [2:0] en, input logic [1:0] mute, input int tick2_at,
                           input int clr_at, input int chg_at, input int rst_at);
    int unsigned v;
    @(posedge clk); #1;
    voice_en   = en;
    mute_voice = mute;
    freq_words = cur_freq;
    frame_freq = cur_freq;
    tick       = 1'b1;
    r_mask = 0; r_nstarts = 0; r_nvalid = 0; r_valid_cyc = 0; r_busy1 = 0;
    r_voices = '0; r_freq2 = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      tick   = (k == tick2_at);
      clr    = (k == clr_at);
      rst_ni = 1'b1;
      if (k == chg_at) begin
        cur_freq[47:32] = 16'h0ABC;
        freq_words = cur_freq;
      end
      if (k == rst_at) begin
        rst_ni = 1'b0;
        #1;
        chk("rst_start", 32'(gen_bus.start), 0);
        chk("rst_voice", 32'(gen_bus.voice), 0);
        chk("rst_samples", 32'(samples), 0);
        chk("rst_valid", 32'(frame_valid), 0);
        chk("rst_busy", 32'(busy), 0);
      end
      if (k == 1) r_busy1 = busy;
      if (gen_bus.start) begin
        v = gen_bus.voice;
        r_mask |= (32'd1 << k);
        if (r_nstarts < 4) r_voices[2*r_nstarts +: 2] = gen_bus.voice;
        r_nstarts++;
        chk("start_freq", 32'(gen_bus.freq), 32'(frame_freq[16*v +: 16]));
        chk("start_wsel", 32'(gen_bus.wave_sel), 32'(wave_sels[4*v +: 4]));
        if (v == 2) r_freq2 = gen_bus.freq;
      end
      if (frame_valid) begin
        r_nvalid++;
        r_valid_cyc = k;
      end
    end
    tick = 1'b0;
    clr  = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  en;
    logic [1:0]  mute;
    int unsigned mask;
    int unsigned nstarts;
    logic [7:0]  voices;
    int unsigned valid_cyc;
    logic [29:0] samples;
    logic        timeout;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{3'b111, 2'd3, 32'h0000_0222, 3, 8'h24, 14, {10'h102, 10'h101, 10'h100}, 1'b0};
    vecs[1] = '{3'b010, 2'd3, 32'h0000_0004, 1, 8'h01,  8, {10'h000, 10'h101, 10'h000}, 1'b0};
    vecs[2] = '{3'b000, 2'd3, 32'h0000_0000, 0, 8'h00,  5, {10'h000, 10'h000, 10'h000}, 1'b0};
    vecs[3] = '{3'b101, 2'd3, 32'h0000_0042, 2, 8'h08, 11, {10'h102, 10'h000, 10'h100}, 1'b0};
    vecs[4] = '{3'b111, 2'd1, 32'h0020_0022, 3, 8'h24, 26, {10'h102, 10'h000, 10'h100}, 1'b1};
    cur_freq = {16'h0800, 16'h2000, 16'h1000};

    #1;
    chk("reset_samples", 32'(samples), 0);
    chk("reset_valid", 32'(frame_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_start", 32'(gen_bus.start), 0);
    chk("reset_overrun", 32'(overrun), 0);
    chk("reset_timeout", 32'(timeout), 0);
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    for (int i = 0; i < 5; i++) begin
      pulse_clr();
      run_frame(vecs[i].en, vecs[i].mute, 0, 0, 0, 0);
      chk($sformatf("v%0d_busy1", i), r_busy1, 1);
      chk($sformatf("v%0d_start_cycles", i), r_mask, vecs[i].mask);
      chk($sformatf("v%0d_nstarts", i), r_nstarts, vecs[i].nstarts);
      chk($sformatf("v%0d_voices", i), 32'(r_voices), 32'(vecs[i].voices));
      chk($sformatf("v%0d_nvalid", i), r_nvalid, 1);
      chk($sformatf("v%0d_valid_cycle", i), r_valid_cyc, vecs[i].valid_cyc);
      chk($sformatf("v%0d_samples", i), 32'(samples), 32'(vecs[i].samples));
      chk($sformatf("v%0d_timeout", i), 32'(timeout), 32'(vecs[i].timeout));
      chk($sformatf("v%0d_overrun", i), 32'(overrun), 0);
      chk($sformatf("v%0d_busy_end", i), 32'(busy), 0);
    end

    pulse_clr();
    chk("timeout_cleared", 32'(timeout), 0);

    run_frame(3'b111, 2'd3, 6, 0, 0, 0);
    chk("ovr_nvalid", r_nvalid, 1);
    chk("ovr_valid_cycle", r_valid_cyc, 14);
    chk("ovr_flag", 32'(overrun), 1);
    pulse_clr();
    chk("ovr_cleared", 32'(overrun), 0);
    run_frame(3'b111, 2'd3, 6, 6, 0, 0);
    chk("ovr_set_wins", 32'(overrun), 1);
    pulse_clr();
    chk("ovr_cleared2", 32'(overrun), 0);

    run_frame(3'b111, 2'd3, 0, 0, 2, 0);
    chk("cfg_old_freq2", 32'(r_freq2), 32'h0800);
    chk("cfg_samples", 32'(samples), 32'({10'h102, 10'h101, 10'h100}));
    run_frame(3'b111, 2'd3, 0, 0, 0, 0);
    chk("cfg_new_freq2", 32'(r_freq2), 32'h0ABC);
    cur_freq = {16'h0800, 16'h2000, 16'h1000};

    run_frame(3'b111, 2'd3, 0, 0, 0, 7);
    chk("rstmid_nvalid", r_nvalid, 0);
    chk("rstmid_samples", 32'(samples), 0);
    chk("rstmid_busy", 32'(busy), 0);
    run_frame(3'b111, 2'd3, 0, 0, 0, 0);
    chk("post_rst_valid_cycle", r_valid_cyc, 14);
    chk("post_rst_nvalid", r_nvalid, 1);
    chk("post_rst_samples", 32'(samples), 32'({10'h102, 10'h101, 10'h100}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench exceeded its time limit");
  end

endmodule

// File: doc/voice_sequencer.md
Name: voice_sequencer

Overview:
- Per-sample scheduler for the shared time-multiplexed voice generator.
- On each sample tick it snapshots the per-voice configuration, then runs voices 0..NUM_VOICES-1 through the generator one at a time using the generator's start/ready handshake.
- Captures each voice's waveform sample and publishes a coherent frame of samples to the downstream mixer/filter stage.
- Skips disabled voices, and recovers from a stalled generator via a watchdog.

Parameters:
- NUM_VOICES, 3, voices sequenced per frame (generator voice index is 2 bits; max 4)
- WAVE_W, 10, width of each voice sample
- TIMEOUT_CYCLES, 15, max cycles in WAIT before a voice is aborted (>=4)

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset
- sample_tick_i  in  1  one-cycle sample-rate strobe
- voice_en_i  in  NUM_VOICES  per-voice enable (gate)
- freq_words_i  in  16*NUM_VOICES  voice v at [16v+15:16v]
- pw_words_i  in  12*NUM_VOICES  voice v at [12v+11:12v]
- wave_sels_i  in  4*NUM_VOICES  voice v at [4v+3:4v], one-hot
- clr_status_i  in  1  clears sticky overrun_o/timeout_o
- gen_start_o  out  1  generator start strobe
- gen_voice_o  out  2  active voice index to generator
- gen_freq_o  out  16  frequency word of active voice
- gen_pw_o  out  12  pulse width of active voice
- gen_wave_sel_o  out  4  waveform select of active voice
- gen_ready_i  in  1  generator done pulse (registered, 1 cycle)
- gen_wave_i  in  WAVE_W  generator sample, valid while gen_ready_i=1
- samples_o  out  WAVE_W*NUM_VOICES  published frame; voice v at [WAVE_W*v+WAVE_W-1:WAVE_W*v]
- frame_valid_o  out  1  one-cycle pulse when samples_o updates
- busy_o  out  1  high in any state other than IDLE
- overrun_o  out  1  sticky: tick arrived while busy
- timeout_o  out  1  sticky: a voice hit the watchdog

Behaviour:
- Reset is asynchronous, active-low, on rst_ni; clock is clk_i.
  - Reset values: state IDLE, voice index 0, gen_start_o=0, gen_voice_o=0, samples_o=0, frame_valid_o=0, overrun_o=0, timeout_o=0, and snapshot/work buffers cleared.
- FSM states: IDLE, SEL, WAIT, DONE.
  - IDLE: on sample_tick_i, latch voice_en/freq/pw/wave_sel into the snapshot, set idx=0, go to SEL.
  - SEL, voice enabled: assert gen_start_o for exactly this cycle, clear the watchdog, go to WAIT.
  - SEL, voice disabled: write work[idx]=0, no start. If idx is the last voice go to DONE, else idx++ and stay in SEL.
  - WAIT: if gen_ready_i, work[idx]=gen_wave_i. If the watchdog reaches TIMEOUT_CYCLES first, work[idx]=0 and set timeout_o. Either way, if idx is the last voice go to DONE, else idx++ and go to SEL.
  - DONE: samples_o<=work (all voices at once), frame_valid_o=1 next cycle, go to IDLE.
- gen_voice_o and gen_freq_o/gen_pw_o/gen_wave_sel_o are driven from snapshot[idx]. They are stable from SEL through the capture cycle.
- Configuration changes during a frame affect only the next frame.
- Generator handshake: ready arrives 3 cycles after the start cycle, so an enabled voice costs 4 cycles (SEL + 3 WAIT) and a disabled voice costs 1.
- Latency: tick sampled in cycle 0 gives frame_valid_o high in cycle 4E+(NUM_VOICES-E)+2, where E is the number of enabled voices.
  - All 3 enabled: cycle 14.
  - None enabled: cycle 5.
- gen_ready_i outside WAIT is ignored.
- sample_tick_i in SEL/WAIT/DONE: the tick is dropped, overrun_o is set, and the current frame completes normally.
- clr_status_i clears overrun_o and timeout_o. If a set event and clr_status_i occur in the same cycle, set wins.
- samples_o holds its value between frames.
- Reset mid-frame: abort immediately, no frame_valid_o, and samples_o returns to 0.

Decomposition:
- Package voice_pkg:
  - typedef seq_state_e (IDLE, SEL, WAIT, DONE)
  - constants VOICE_IDX_W=2, FREQ_W=16, PW_W=12, WSEL_W=4
  - the one-hot wave select encodings: TRI 0001, SAW 0010, PULSE 0100, NOISE 1000
- No sub-module required.
- The watchdog counter is inline; splitting it into a sub-module is optional.

Test Plan:
- All voices enabled, freq={0x1000,0x2000,0x0800}, generator model returns wave=0x100+v, tick at cycle 0 -> three gen_start_o pulses at cycles 1,5,9 with gen_voice_o=0,1,2; frame_valid_o at cycle 14; samples_o={0x102,0x101,0x100}.
- voice_en_i=3'b010 -> one start at cycle 2 with gen_voice_o=1; frame_valid_o at cycle 8; samples for voices 0 and 2 equal 0.
- Second tick at cycle 6 of a frame -> overrun_o=1, exactly one frame_valid_o. Pulse clr_status_i -> overrun_o=0.
- Generator model never asserts ready for voice 1 -> voice 1 aborted after TIMEOUT_CYCLES=15, sample 0, timeout_o=1. Voices 0 and 2 still captured, frame completes.
- Change freq_words_i for voice 2 during WAIT of voice 0 -> gen_freq_o for voice 2 shows the old value. The next frame uses the new value.
- Assert rst_ni low during WAIT of voice 1 -> all outputs go to their reset values, no frame_valid_o. After release, the next tick produces a normal frame.
